// File: rtl/freq_meter_ctrl_if.sv
// Signal bundle between the frequency-meter controller and its environment.
// The done pulse exists only when FREQ_METER_DONE_PULSE_EN is defined.
interface freq_meter_ctrl_if;
   logic start;
   logic sig_in;
   logic enb_machine;
   logic cnt_enable;
   logic cnt_rst;
   logic cnt_ld;
   logic gate;
   logic busy;
   logic overflow;
`ifdef FREQ_METER_DONE_PULSE_EN
   logic done;
`endif

   modport master (
      output start,
      output sig_in,
      output enb_machine,
      input  cnt_enable,
      input  cnt_rst,
      input  cnt_ld,
      input  gate,
      input  busy,
`ifdef FREQ_METER_DONE_PULSE_EN
      input  done,
`endif
      input  overflow
   );

   modport slave (
      input  start,
      input  sig_in,
      input  enb_machine,
      output cnt_enable,
      output cnt_rst,
      output cnt_ld,
      output gate,
      output busy,
`ifdef FREQ_METER_DONE_PULSE_EN
      output done,
`endif
      output overflow
   );
endinterface

// File: rtl/freq_meter_ctrl.sv
// Gate/load controller for a 3-digit BCD frequency counter chain.
// Define FREQ_METER_DONE_PULSE_EN to add a one-cycle done pulse after each load.
module freq_meter_ctrl #(
   parameter int unsigned GATE_CYCLES = 1000,
   parameter int unsigned HOLD_CYCLES = 250,
   parameter int unsigned CNT_W       = 16
) (
   input logic             clk,
   input logic             rst,
   freq_meter_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StGate,
      StSettle,
      StLoad,
      StHold
   } state_e;

   localparam logic [CNT_W-1:0] GateLast = CNT_W'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HoldLast = CNT_W'(HOLD_CYCLES - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic [2:0]       sync_q, sync_d;
   logic             ovf_sticky_q, ovf_sticky_d;
   logic             overflow_q, overflow_d;
   logic             cnt_enable_q, cnt_enable_d;
   logic             rise;
   logic             in_gate;
`ifdef FREQ_METER_DONE_PULSE_EN
   logic             done_q, done_d;
`endif

   // sync_q[0..1] is the metastability chain, sync_q[2] holds the previous sample.
   assign sync_d  = {sync_q[1:0], bus.sig_in};
   assign rise    = sync_q[1] & ~sync_q[2];
   assign in_gate = (state_q == StGate);

   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q;
      ovf_sticky_d = ovf_sticky_q;
      overflow_d   = overflow_q;
      cnt_enable_d = rise & in_gate & ~ovf_sticky_q & ~bus.enb_machine;

      // A rise arriving while the chain shows 999 latches overflow for the rest of the window.
      if (rise && in_gate && bus.enb_machine) begin
         ovf_sticky_d = 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               state_d = StClear;
            end
         end
         StClear: begin
            ovf_sticky_d = 1'b0;
            timer_d      = '0;
            state_d      = StGate;
         end
         StGate: begin
            if (timer_q == GateLast) begin
               timer_d = '0;
               state_d = StSettle;
            end else begin
               timer_d = timer_q + CNT_W'(1);
            end
         end
         StSettle: begin
            state_d = StLoad;
         end
         StLoad: begin
            overflow_d = ovf_sticky_q;
            timer_d    = '0;
            state_d    = StHold;
         end
         StHold: begin
            if (timer_q == HoldLast) begin
               timer_d = '0;
               state_d = bus.start ? StClear : StIdle;
            end else begin
               timer_d = timer_q + CNT_W'(1);
            end
         end
         default: begin
            timer_d = '0;
            state_d = StIdle;
         end
      endcase
   end

`ifdef FREQ_METER_DONE_PULSE_EN
   assign done_d = (state_q == StLoad);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         done_q <= 1'b0;
      end else begin
         done_q <= done_d;
      end
   end

   assign bus.done = done_q;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         timer_q      <= '0;
         sync_q       <= '0;
         ovf_sticky_q <= 1'b0;
         overflow_q   <= 1'b0;
         cnt_enable_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         sync_q       <= sync_d;
         ovf_sticky_q <= ovf_sticky_d;
         overflow_q   <= overflow_d;
         cnt_enable_q <= cnt_enable_d;
      end
   end

   assign bus.cnt_enable = cnt_enable_q;
   assign bus.cnt_rst    = (state_q == StClear);
   assign bus.cnt_ld     = (state_q == StLoad);
   assign bus.gate       = in_gate;
   assign bus.busy       = (state_q != StIdle);
   assign bus.overflow   = overflow_q;

endmodule
